exibe_sequencia_leds: RTL and testbench

- Transmitter side of the player interface: reads the stored jogada sequence from memory and plays it back on the LEDs with fixed on/off timing. The game's button-reading path is the receiving side.
- Sits beside the fluxo de dados. While `exibindo` is high it owns the memory address; the UC starts it and waits for `pronto` before enabling play input.

---
 rtl/exibe_sequencia_leds_if.sv | 26 ++
 rtl/exibe_sequencia_leds.sv | 105 ++++++++++
 tb/tb_exibe_sequencia_leds.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/exibe_sequencia_leds_if.sv
// Player-side bus of the LED playback block: start/abort control, memory port,
// LED output and status.
interface exibe_sequencia_leds_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4
);
   logic                  iniciar;
   logic                  cancelar;
   logic [ADDR_WIDTH-1:0] limite;
   logic [DATA_WIDTH-1:0] dado_memoria;
   logic [ADDR_WIDTH-1:0] endereco;
   logic [DATA_WIDTH-1:0] leds;
   logic                  exibindo;
   logic                  pronto;
   logic [3:0]            db_estado;

   // master: control unit + memory; slave: the playback block
   modport master (
      output iniciar, cancelar, limite, dado_memoria,
      input  endereco, leds, exibindo, pronto, db_estado
   );
   modport slave (
      input  iniciar, cancelar, limite, dado_memoria,
      output endereco, leds, exibindo, pronto, db_estado
   );
endinterface

// File: rtl/exibe_sequencia_leds.sv
// Plays the stored jogada sequence back on the LEDs: each word shown for T_ON
// cycles, then T_OFF dark cycles, addresses 0..limite, then a one-cycle pronto.
module exibe_sequencia_leds #(
   parameter int T_ON       = 1000,
   parameter int T_OFF      = 500,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   exibe_sequencia_leds_if.slave  bus
);
   localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TW-1:0]         ULT_ON  = TW'(T_ON - 1);
   localparam logic [TW-1:0]         ULT_OFF = TW'(T_OFF - 1);
   localparam logic [ADDR_WIDTH-1:0] END_MAX = '1;

   typedef enum logic [3:0] {
      INICIAL = 4'h0,
      PREPARA = 4'h1,
      CARREGA = 4'h2,
      ACENDE  = 4'h3,
      APAGA   = 4'h4,
      PROXIMO = 4'h5,
      FIM     = 4'hF
   } estado_t;

   estado_t               estado, estado_n;
   logic [ADDR_WIDTH-1:0] endereco_q, endereco_n;
   logic [DATA_WIDTH-1:0] leds_q, leds_n;
   logic [TW-1:0]         timer, timer_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= INICIAL;
         endereco_q <= '0;
         leds_q     <= '0;
         timer      <= '0;
      end else begin
         estado     <= estado_n;
         endereco_q <= endereco_n;
         leds_q     <= leds_n;
         timer      <= timer_n;
      end
   end

   always_comb begin
      estado_n   = estado;
      endereco_n = endereco_q;
      leds_n     = leds_q;
      timer_n    = timer;
      // abort wins over everything; endereco is deliberately left untouched
      if (bus.cancelar) begin
         estado_n = INICIAL;
         leds_n   = '0;
         timer_n  = '0;
      end else begin
         case (estado)
            INICIAL: if (bus.iniciar) estado_n = PREPARA;
            PREPARA: begin
               endereco_n = '0;
               timer_n    = '0;
               estado_n   = CARREGA;
            end
            CARREGA: begin
               leds_n   = bus.dado_memoria;
               estado_n = ACENDE;
            end
            ACENDE: begin
               if (timer == ULT_ON) begin
                  leds_n   = '0;
                  timer_n  = '0;
                  estado_n = APAGA;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            APAGA: begin
               // stopping at END_MAX too keeps endereco from wrapping when
               // limite moved below the current address mid-playback
               if (timer == ULT_OFF) begin
                  timer_n  = '0;
                  estado_n = (endereco_q == bus.limite || endereco_q == END_MAX)
                             ? FIM : PROXIMO;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            PROXIMO: begin
               endereco_n = endereco_q + 1'b1;
               estado_n   = CARREGA;
            end
            FIM:     estado_n = INICIAL;
            default: estado_n = INICIAL;
         endcase
      end
   end

   assign bus.endereco  = endereco_q;
   assign bus.leds      = leds_q;
   assign bus.db_estado = estado;
   assign bus.pronto    = (estado == FIM);
   assign bus.exibindo  = (estado != INICIAL) && (estado != FIM);
endmodule

// File: tb/tb_exibe_sequencia_leds.sv
// Scoreboard bench: each start pushes the per-cycle expected playback trace;
// a negedge monitor pops one entry per cycle the DUT is active or signals pronto.
module tb_exibe_sequencia_leds;
   localparam int T_ON  = 4;
   localparam int T_OFF = 2;

   typedef struct {
      logic [3:0] leds;
      logic [3:0] addr;
      logic       chk_addr;
      logic       pronto;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   exibe_sequencia_leds_if #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) bus();

   exibe_sequencia_leds #(
      .T_ON(T_ON), .T_OFF(T_OFF), .ADDR_WIDTH(4), .DATA_WIDTH(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   logic [3:0] mem [16];
   assign bus.dado_memoria = mem[bus.endereco];

   exp_t sb_q[$];
   exp_t trace[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   function automatic exp_t mk(input int l, input int a, input bit p);
      exp_t e;
      e.leds = 4'(l); e.addr = 4'(a); e.chk_addr = 1'b1; e.pronto = p;
      return e;
   endfunction

   // Expected trace from the playback rules: 1 prepare cycle, then per element
   // 1 load + T_ON lit + T_OFF dark (+1 advance unless last), then pronto.
   task automatic start(input int lim, input int npush);
      exp_t e;
      trace.delete();
      e = mk(0, 0, 0); e.chk_addr = 1'b0;
      trace.push_back(e);
      for (int i = 0; i <= lim; i++) begin
         trace.push_back(mk(0, i, 0));
         for (int t = 0; t < T_ON; t++)  trace.push_back(mk(mem[i], i, 0));
         for (int t = 0; t < T_OFF; t++) trace.push_back(mk(0, i, 0));
         if (i != lim) trace.push_back(mk(0, i, 0));
      end
      trace.push_back(mk(0, lim, 1));
      for (int k = 0; k < trace.size() && k < npush; k++) sb_q.push_back(trace[k]);
      bus.limite  = 4'(lim);
      bus.iniciar = 1'b1;
      @(posedge clock); #1;
      bus.iniciar = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (sb_q.size() != 0 && k < 600) begin
         @(negedge clock);
         k++;
      end
      check("drain", sb_q.size(), 0);
      @(negedge clock);
      check("idle_estado", bus.db_estado, 0);
      check("idle_exibindo", bus.exibindo, 0);
      @(posedge clock); #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (bus.exibindo || bus.pronto) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", {bus.exibindo, bus.pronto}, 2'b00);
            end else begin
               e = sb_q.pop_front();
               check("trace",
                     {bus.leds, (e.chk_addr ? bus.endereco : 4'h0), bus.pronto, bus.exibindo},
                     {e.leds,   (e.chk_addr ? e.addr       : 4'h0), e.pronto,   ~e.pronto});
            end
         end
      end
   end

   initial begin
      reset        = 1'b1;
      bus.iniciar  = 1'b0;
      bus.cancelar = 1'b0;
      bus.limite   = '0;
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
      mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;

      #12;
      check("rst_leds", bus.leds, 0);
      check("rst_endereco", bus.endereco, 0);
      check("rst_estado", bus.db_estado, 0);
      check("rst_flags", {bus.exibindo, bus.pronto}, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      start(2, 1000); wait_done();
      start(0, 1000); wait_done();
      start(3, 1000); wait_done();

      // iniciar re-pulsed during ACENDE of address 1 (cycle 12)
      start(2, 1000);
      repeat (11) @(posedge clock);
      #1 bus.iniciar = 1'b1;
      @(posedge clock); #1 bus.iniciar = 1'b0;
      wait_done();

      // cancelar in cycle 12: only cycles 1..12 are playback
      start(2, 12);
      repeat (11) @(posedge clock);
      #1 bus.cancelar = 1'b1;
      @(posedge clock); #1 bus.cancelar = 1'b0;
      check("cancel_estado", bus.db_estado, 0);
      check("cancel_leds", bus.leds, 0);
      check("cancel_flags", {bus.exibindo, bus.pronto}, 0);
      repeat (6) @(posedge clock);
      #1 check("cancel_drain", sb_q.size(), 0);
      start(1, 1000); wait_done();

      start(15, 1000); wait_done();

      // async reset in APAGA of address 1 (cycle 15), between edges
      start(2, 1000);
      repeat (14) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("arst_leds", bus.leds, 0);
      check("arst_endereco", bus.endereco, 0);
      check("arst_estado", bus.db_estado, 0);
      @(posedge clock); #1;
      sb_q.delete();
      reset = 1'b0;
      @(posedge clock); #1;
      start(1, 1000); wait_done();

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
         start(int'($urandom_range(0, 6)), 1000);
         wait_done();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
